// File: rtl/spi_dac_receiver_if.sv
// SPI slave receiver bus: serial inputs from the link master plus the
// deserialised word, strobes and status seen by the consumer.
interface spi_dac_receiver_if #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
);
    logic                  spi_clk;
    logic                  spi_mosi;
    logic                  spi_ss;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  frame_error;
    logic [CNT_WIDTH-1:0]  frame_count;
    logic                  busy;
    logic [1:0]            debug_state;

    // data_valid is a one-cycle strobe with no backpressure: the consumer must
    // take data_out in that cycle or rely on data_out holding until the next word.
    modport master (
        output spi_clk, spi_mosi, spi_ss,
        input  data_out, data_valid, frame_error, frame_count, busy, debug_state
    );

    modport slave (
        input  spi_clk, spi_mosi, spi_ss,
        output data_out, data_valid, frame_error, frame_count, busy, debug_state
    );
endinterface

// File: rtl/spi_dac_receiver.sv
// Oversampling SPI mode-0 slave: synchronises the link, deserialises MSB-first
// frames and reports good words, malformed frames and stalled frames.
module spi_dac_receiver #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_WIDTH      = 16
) (
    input  logic               clk,
    input  logic               reset,
    spi_dac_receiver_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        OVER  = 2'd2,
        ABORT = 2'd3
    } state_t;

    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [BW-1:0] BITS_FULL = BW'(DATA_WIDTH);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    logic sclk_s1, sclk_s2, sclk_q;
    logic ss_s1, ss_s2, ss_q;
    logic mosi_s1, mosi_s2, mosi_q;
    logic sclk_rise, ss_rise, ss_fall;
    logic [1:0] settle;
    logic armed;

    state_t                state;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [TW-1:0]         tmo_cnt;
    logic [DATA_WIDTH-1:0] data_out_r;
    logic                  data_valid_r;
    logic                  frame_error_r;
    logic [CNT_WIDTH-1:0]  frame_count_r;

    // Edge pulses are registered, so mosi_q is delayed alongside them and is
    // the bit value present when the sclk rise was detected.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_q    <= 1'b0;
            ss_s1     <= 1'b1;
            ss_s2     <= 1'b1;
            ss_q      <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            mosi_q    <= 1'b0;
            sclk_rise <= 1'b0;
            ss_rise   <= 1'b0;
            ss_fall   <= 1'b0;
        end else begin
            sclk_s1   <= bus.spi_clk;
            sclk_s2   <= sclk_s1;
            sclk_q    <= sclk_s2;
            ss_s1     <= bus.spi_ss;
            ss_s2     <= ss_s1;
            ss_q      <= ss_s2;
            mosi_s1   <= bus.spi_mosi;
            mosi_s2   <= mosi_s1;
            mosi_q    <= mosi_s2;
            sclk_rise <= sclk_s2 & ~sclk_q;
            ss_rise   <= ss_s2 & ~ss_q;
            ss_fall   <= ~ss_s2 & ss_q;
        end
    end

    // The synchronisers reset to ss high, so a select already low at reset
    // release would look like a fresh falling edge. Frames are accepted only
    // once the pipeline has flushed and ss has been seen high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            settle <= 2'd0;
            armed  <= 1'b0;
        end else begin
            if (settle != 2'd3) settle <= settle + 2'd1;
            if (settle == 2'd3 && ss_q) armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            tmo_cnt       <= '0;
            data_out_r    <= '0;
            data_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
            frame_count_r <= '0;
        end else begin
            data_valid_r  <= 1'b0;
            frame_error_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (ss_fall && armed) begin
                        state     <= SHIFT;
                        bit_cnt   <= '0;
                        shift_reg <= '0;
                        tmo_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (ss_rise) begin
                        state <= IDLE;
                        if (bit_cnt == BITS_FULL) begin
                            data_out_r    <= shift_reg;
                            data_valid_r  <= 1'b1;
                            frame_count_r <= frame_count_r + 1'b1;
                        end else begin
                            frame_error_r <= 1'b1;
                        end
                    end else if (sclk_rise) begin
                        tmo_cnt <= '0;
                        if (bit_cnt == BITS_FULL) begin
                            state <= OVER;
                        end else begin
                            shift_reg <= {shift_reg[DATA_WIDTH-2:0], mosi_q};
                            bit_cnt   <= bit_cnt + 1'b1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        state         <= ABORT;
                        frame_error_r <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                OVER: begin
                    if (ss_rise) begin
                        state         <= IDLE;
                        frame_error_r <= 1'b1;
                    end else if (sclk_rise) begin
                        tmo_cnt <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state         <= ABORT;
                        frame_error_r <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ABORT: begin
                    if (ss_rise) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_out    = data_out_r;
    assign bus.data_valid  = data_valid_r;
    assign bus.frame_error = frame_error_r;
    assign bus.frame_count = frame_count_r;
    assign bus.busy        = (state == SHIFT) || (state == OVER);
    assign bus.debug_state = state;
endmodule

// File: tb/tb_spi_dac_receiver.sv
// Bench for spi_dac_receiver: frame-level model predicts each strobe, its
// cycle, the held word and the wrapping good-frame count.
module tb_spi_dac_receiver;
    localparam int W  = 8;
    localparam int T  = 64;
    localparam int CW = 3;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    spi_dac_receiver_if #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) bus();

    spi_dac_receiver #(
        .DATA_WIDTH(W),
        .TIMEOUT_CYCLES(T),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard
    logic [W-1:0]  exp_q[$];
    int            exp_cyc_q[$];
    bit            exp_err_q[$];
    logic [W-1:0]  m_data;
    logic [CW-1:0] m_cnt;
    bit            chk_en = 1'b0;
    int            n_vec  = 0;
    int            n_fail = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void push(input int c, input bit is_err, input logic [W-1:0] d);
        exp_cyc_q.push_back(c);
        exp_err_q.push_back(is_err);
        exp_q.push_back(d);
    endfunction

    always @(negedge clk) begin : cmp
        bit want_v;
        bit want_e;
        want_v = 1'b0;
        want_e = 1'b0;
        if (chk_en) begin
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                want_e = exp_err_q[0];
                want_v = !exp_err_q[0];
                if (want_v) begin
                    m_data = exp_q[0];
                    m_cnt  = m_cnt + 1'b1;
                end
                void'(exp_cyc_q.pop_front());
                void'(exp_err_q.pop_front());
                void'(exp_q.pop_front());
            end
            check("data_valid", 32'(bus.data_valid), 32'(want_v));
            check("frame_error", 32'(bus.frame_error), 32'(want_e));
            check("data_out", 32'(bus.data_out), 32'(m_data));
            check("frame_count", 32'(bus.frame_count), 32'(m_cnt));
        end
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_bits(input logic [15:0] bits, input int hi, input int lo, input int half);
        for (int i = hi; i >= lo; i--) begin
            bus.spi_mosi = bits[i];
            tick(half);
            bus.spi_clk = 1'b1;
            tick(half);
            bus.spi_clk = 1'b0;
        end
    endtask

    // A frame with exactly W bits yields its word 4 cycles after ss rises;
    // any other bit count yields an error strobe at that same cycle.
    task automatic send_frame(input logic [15:0] bits, input int nbits, input int half, input int gap);
        bus.spi_ss = 1'b0;
        tick(half);
        if (nbits > 0) pulse_bits(bits, nbits - 1, 0, half);
        if (nbits > W) begin
            tick(5);
            check("over_state", 32'(bus.debug_state), 32'd2);
            check("over_busy", 32'(bus.busy), 32'd1);
        end
        tick(half);
        bus.spi_ss = 1'b1;
        push(cyc + 4, nbits != W, bits[W-1:0]);
        if ($urandom_range(0, 3) == 0) begin
            tick(1);
            bus.spi_clk = 1'b1;
            tick(3);
            bus.spi_clk = 1'b0;
            tick(3);
        end
        tick(gap);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        chk_en = 1'b0;
        exp_q.delete();
        exp_cyc_q.delete();
        exp_err_q.delete();
        m_data = '0;
        m_cnt  = '0;
    endtask

    initial begin : main
        int e;
        int nb;
        logic [15:0] rb;
        reset        = 1'b0;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        bus.spi_ss   = 1'b1;
        #1;
        do_reset();
        tick(3);
        check("rst_data_out", 32'(bus.data_out), 32'h0);
        check("rst_valid", 32'(bus.data_valid), 32'h0);
        check("rst_error", 32'(bus.frame_error), 32'h0);
        check("rst_count", 32'(bus.frame_count), 32'h0);
        check("rst_busy", 32'(bus.busy), 32'h0);
        check("rst_state", 32'(bus.debug_state), 32'h0);
        reset  = 1'b0;
        chk_en = 1'b1;
        tick(8);

        send_frame(16'h00A5, 8, 20, 6);
        check("a5_data", 32'(bus.data_out), 32'hA5);
        check("a5_count", 32'(bus.frame_count), 32'h1);
        check("a5_busy", 32'(bus.busy), 32'h0);
        check("a5_state", 32'(bus.debug_state), 32'h0);

        send_frame(16'h0055, 7, 4, 6);
        check("short_data", 32'(bus.data_out), 32'hA5);
        send_frame(16'h01C3, 9, 6, 6);
        check("long_data", 32'(bus.data_out), 32'hA5);
        check("long_count", 32'(bus.frame_count), 32'h1);

        // stalled frame: three bits, then sclk stops with ss held low
        bus.spi_ss = 1'b0;
        tick(4);
        pulse_bits(16'h0005, 2, 1, 4);
        bus.spi_mosi = 1'b1;
        tick(4);
        bus.spi_clk = 1'b1;
        e = cyc;
        tick(4);
        bus.spi_clk = 1'b0;
        push(e + 4 + T, 1'b1, '0);
        tick(T + 12);
        check("abort_state", 32'(bus.debug_state), 32'd3);
        check("abort_busy", 32'(bus.busy), 32'd0);
        bus.spi_ss = 1'b1;
        tick(6);
        check("abort_exit", 32'(bus.debug_state), 32'd0);

        send_frame(16'h003C, 8, 5, 6);
        check("3c_data", 32'(bus.data_out), 32'h3C);
        check("3c_count", 32'(bus.frame_count), 32'h2);

        send_frame(16'h0000, 8, 3, 4);
        send_frame(16'h00FF, 8, 3, 4);
        send_frame(16'h0081, 8, 3, 4);
        tick(6);
        check("b2b_data", 32'(bus.data_out), 32'h81);
        check("b2b_count", 32'(bus.frame_count), 32'h5);

        // reset in the middle of a frame, with ss toggling during reset
        bus.spi_ss = 1'b0;
        tick(4);
        pulse_bits(16'h000B, 3, 0, 4);
        do_reset();
        tick(2);
        check("mid_rst_data", 32'(bus.data_out), 32'h0);
        check("mid_rst_count", 32'(bus.frame_count), 32'h0);
        check("mid_rst_error", 32'(bus.frame_error), 32'h0);
        check("mid_rst_busy", 32'(bus.busy), 32'h0);
        for (int i = 0; i < 4; i++) begin
            bus.spi_ss = ~bus.spi_ss;
            tick(3);
        end
        check("mid_rst_state", 32'(bus.debug_state), 32'h0);
        reset  = 1'b0;
        chk_en = 1'b1;
        tick(4);
        pulse_bits(16'h000F, 3, 0, 4);
        tick(4);
        bus.spi_ss = 1'b1;
        tick(10);
        check("post_rst_idle", 32'(bus.debug_state), 32'h0);

        // eight good frames wrap the 3-bit counter back to zero
        for (int i = 0; i < 8; i++) send_frame(16'(8'h11 * i), 8, 3, 5);
        check("wrap_count", 32'(bus.frame_count), 32'h0);
        check("wrap_data", 32'(bus.data_out), 32'h77);

        for (int i = 0; i < 30; i++) begin
            rb = 16'($urandom);
            case ($urandom_range(0, 9))
                7:       nb = W - 1;
                8:       nb = W + 1;
                9:       nb = $urandom_range(0, 3);
                default: nb = W;
            endcase
            send_frame(rb, nb, $urandom_range(3, 6), $urandom_range(4, 8));
        end
        tick(10);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/spi_dac_receiver.md
Name: spi_dac_receiver

Overview:
- SPI slave receiver: the far end of the diodController SPI link, modelling the DAC input stage.
- Oversamples spi_clk/spi_ss/spi_mosi in the system clock domain and deserialises MSB-first words.
- Presents each good word as a held level with a one-cycle valid strobe, and flags malformed frames.
- Used in simulation as a DAC model and on hardware as a loopback checker against debug_voltage.

Parameters:
- DATA_WIDTH, 8, bits per SPI frame
- TIMEOUT_CYCLES, 4096, clk cycles with spi_ss low and no spi_clk edge before the frame is aborted
- CNT_WIDTH, 16, width of frame_count

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- spi_clk  input  1  SPI serial clock from master (mode 0, idle low)
- spi_mosi  input  1  SPI data, MSB first
- spi_ss  input  1  slave select, active low
- data_out  output  DATA_WIDTH  last correctly received word, held
- data_valid  output  1  one-cycle pulse when data_out updates
- frame_error  output  1  one-cycle pulse on a malformed or aborted frame
- frame_count  output  CNT_WIDTH  number of good frames since reset, wraps
- busy  output  1  high while a frame is in progress (state SHIFT or OVER)
- debug_state  output  2  current FSM state encoding

Behaviour:
- Reset (asynchronous, active-high): data_out=0, data_valid=0, frame_error=0, frame_count=0, busy=0, state=IDLE, bit counter=0, shift register=0, timeout counter=0. Synchronizers reset to the idle levels: ss=1, sclk=0, mosi=0.
- Input conditioning:
  - Each of spi_clk, spi_ss, spi_mosi passes through a 2-FF synchronizer, then one edge-detect register.
  - spi_clk high and low phases must each be at least 3 clk cycles for guaranteed capture.
- FSM states (debug_state): IDLE=0, SHIFT=1, OVER=2, ABORT=3.
- IDLE:
  - On synchronized ss falling edge: go to SHIFT, clear bit counter, shift register and timeout counter.
  - sclk edges while ss is high are ignored.
- SHIFT:
  - On each synchronized sclk rising edge: shift register <= {shift[DATA_WIDTH-2:0], mosi_sync}, bit counter++, timeout counter cleared.
  - When the counter reaches DATA_WIDTH and another rising edge arrives: go to OVER.
  - On ss rising edge with count==DATA_WIDTH: data_out<=shift, data_valid=1 for one cycle, frame_count++ (wraps 2^CNT_WIDTH-1 -> 0), go to IDLE.
  - On ss rising edge with count!=DATA_WIDTH (including 0): frame_error=1 for one cycle, data_out unchanged, go to IDLE.
- OVER: extra bits are ignored. On ss rising edge: frame_error pulse, data_out unchanged, go to IDLE.
- ABORT:
  - Entered from SHIFT or OVER when the timeout counter reaches TIMEOUT_CYCLES with ss still low; frame_error pulses on entry.
  - Stays in ABORT until ss rises, then returns to IDLE with no further pulse.
- Latency: data_valid and frame_error assert exactly 4 clk cycles after the spi_ss input rises (2 sync + 1 edge + 1 output register).
- Simultaneous events:
  - An ss rising edge and an sclk rising edge in the same cycle: ss wins and the sclk edge is discarded.
  - data_valid and frame_error are never high in the same cycle.
- Falling sclk edges are not used; mosi is sampled only on the rising edge.
- Asserting reset mid-frame discards the partial frame with no frame_error. After reset, a frame already in progress (ss already low) is not captured; the receiver waits for the next ss falling edge.

Test Plan:
- Reset, then one frame 0xA5 with 8 sclk pulses (20 clk per half-period) -> data_out=0xA5, single data_valid pulse 4 clk after ss rises, frame_count=1, busy=0 afterwards.
- Frame with only 7 bits after 0xA5 -> frame_error pulse, data_out stays 0xA5, frame_count=1; repeat with 9 bits -> state passes through OVER, frame_error pulse, data_out stays 0xA5.
- ss low with 3 bits, then sclk stops for TIMEOUT_CYCLES -> frame_error at timeout, debug_state=3 until ss rises, then IDLE; next frame 0x3C -> data_out=0x3C, frame_count=2.
- Back-to-back frames 0x00, 0xFF, 0x81 with 4 clk of ss high between -> three data_valid pulses in order, frame_count +3.
- Reset asserted after bit 4 of a frame -> all outputs 0, no frame_error; ss toggles while reset is high are ignored.
- Drive diodController into this block and run the start/noise sequence -> every data_out value equals debug_voltage at each spi_ss rise, with zero frame_error pulses.
